// File: rtl/AHB_package.sv
// rtl/AHB_package.sv - shared AHB encodings for the interconnect front ends
package AHB_package;

  // AHB HBURST encoding
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  // AHB HTRANS encoding
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

endpackage

// File: rtl/ahb_master_req_gen.sv
// rtl/ahb_master_req_gen.sv - per-master AHB request decoder, burst tracker and stall generator
//
// Purpose:
//   Sits between one AHB master and the per-slave arbiters. Decodes the
//   master's address phase into a one-hot request, holds it until the target
//   arbiter grants, tracks burst beats while granted, and answers an unmapped
//   slave index with a two-cycle ERROR response.
//
// Ports:
//   hclk        clock, all logic on the rising edge
//   hreset      synchronous active-high reset
//   htrans      master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   haddr       master address; top SEL_BIT bits select the slave
//   hburst      master burst type
//   hgrant      grant from each slave arbiter to this master
//   hreq        registered one-hot request to the slave arbiters
//   hburst_out  burst type latched at acceptance
//   slave_idx   slave index latched at acceptance
//   hready_out  HREADY returned to the master
//   hresp_err   ERROR response flag
module ahb_master_req_gen
  import AHB_package::*;
#(
  parameter int SLAVE_NUM  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BIT    = 3
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  hburst_type            hburst,
  input  logic [SLAVE_NUM-1:0]  hgrant,
  output logic [SLAVE_NUM-1:0]  hreq,
  output hburst_type            hburst_out,
  output logic [SEL_BIT-1:0]    slave_idx,
  output logic                  hready_out,
  output logic                  hresp_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               state;
  logic [3:0]           beat;

  logic [SEL_BIT-1:0]   dec_idx;
  logic                 dec_ok;
  logic [SLAVE_NUM-1:0] dec_onehot;
  logic                 new_xfer;
  logic                 grant_cur;
  logic                 beat_acc;
  logic                 last_beat;
  logic                 take_new;
  logic                 unused_addr_bits;

  // Final beat index (limit-1) of a fixed-length burst; INCR is open-ended
  // and never reaches this comparison.
  function automatic logic [3:0] final_beat_of(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4'd3;
      WRAP8, INCR8:   return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

  assign dec_idx          = haddr[ADDR_WIDTH-1 -: SEL_BIT];
  assign dec_ok           = int'(dec_idx) < SLAVE_NUM;
  assign dec_onehot       = {{(SLAVE_NUM-1){1'b0}}, 1'b1} << dec_idx;
  assign unused_addr_bits = ^haddr[ADDR_WIDTH-SEL_BIT-1:0];
  assign new_xfer         = (htrans == HTRANS_NONSEQ);

  // hreq is one-hot on the latched index while in REQ/XFER, so masking the
  // grant vector with it picks hgrant[slave_idx] without a variable index.
  assign grant_cur = |(hgrant & hreq);

  assign beat_acc = (state == ST_XFER) && grant_cur &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  always_comb begin
    last_beat = 1'b0;
    if (state == ST_XFER) begin
      if (hburst_out == INCR) begin
        // Open-ended burst: the master ends it by leaving the SEQ/BUSY
        // stream while granted.
        last_beat = grant_cur &&
                    ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ));
      end else begin
        last_beat = beat_acc && (beat == final_beat_of(hburst_out));
      end
    end
  end

  // A NONSEQ seen on the last beat starts the next request directly, so the
  // request line moves to the new target without an IDLE cycle.
  assign take_new = new_xfer && ((state == ST_IDLE) || last_beat);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      hreq       <= '0;
      hburst_out <= SINGLE;
      slave_idx  <= '0;
      beat       <= 4'd0;
    end else if (take_new) begin
      slave_idx  <= dec_idx;
      hburst_out <= hburst;
      beat       <= 4'd0;
      if (dec_ok) begin
        state <= ST_REQ;
        hreq  <= dec_onehot;
      end else begin
        state <= ST_ERR1;
        hreq  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          hreq <= '0;
        end
        ST_REQ: begin
          if (grant_cur) begin
            state <= ST_XFER;
            beat  <= 4'd0;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            state <= ST_IDLE;
            hreq  <= '0;
            beat  <= 4'd0;
          end else if (beat_acc) begin
            // BUSY and stalled cycles leave the count untouched.
            beat <= beat + 4'd1;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
        end
        ST_ERR2: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          hreq  <= '0;
        end
      endcase
    end
  end

  // Outputs decode only the registered state, except in XFER where the
  // master follows the live grant so a lost grant stalls it immediately.
  always_comb begin
    hready_out = 1'b1;
    case (state)
      ST_IDLE: hready_out = 1'b1;
      ST_REQ:  hready_out = 1'b0;
      ST_XFER: hready_out = grant_cur;
      ST_ERR1: hready_out = 1'b0;
      ST_ERR2: hready_out = 1'b1;
      default: hready_out = 1'b1;
    endcase
  end

  assign hresp_err = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// tb/tb_ahb_master_req_gen.sv - transaction-level self-checking bench for ahb_master_req_gen
module tb_ahb_master_req_gen;
  import AHB_package::*;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [1:0] htrans;
  logic [31:0] haddr;
  hburst_type hburst;
  logic [7:0] hgrant;
  logic       sel6;

  logic [1:0] htrans8, htrans6;
  logic [7:0] hreq8;
  logic [5:0] hreq6;
  hburst_type hburst_out8, hburst_out6;
  logic [2:0] slave_idx8, slave_idx6;
  logic       hready8, hready6, herr8, herr6;

  logic [7:0] hreq_o;
  hburst_type hburst_o;
  logic [2:0] slave_idx_o;
  logic       hready_o, herr_o;

  int checks = 0;
  int errors = 0;
  bit rnd_en = 1'b0;
  int stall_beat = -1;
  int stall_len = 0;

  always #5 hclk = ~hclk;

  // Only the selected instance sees master traffic; the other idles.
  assign htrans8 = sel6 ? HTRANS_IDLE : htrans;
  assign htrans6 = sel6 ? htrans : HTRANS_IDLE;

  assign hreq_o      = sel6 ? {2'b00, hreq6} : hreq8;
  assign hburst_o    = sel6 ? hburst_out6 : hburst_out8;
  assign slave_idx_o = sel6 ? slave_idx6 : slave_idx8;
  assign hready_o    = sel6 ? hready6 : hready8;
  assign herr_o      = sel6 ? herr6 : herr8;

  ahb_master_req_gen #(.SLAVE_NUM(8), .ADDR_WIDTH(32), .SEL_BIT(3)) dut8 (
    .hclk(hclk), .hreset(hreset), .htrans(htrans8), .haddr(haddr),
    .hburst(hburst), .hgrant(hgrant), .hreq(hreq8), .hburst_out(hburst_out8),
    .slave_idx(slave_idx8), .hready_out(hready8), .hresp_err(herr8)
  );

  ahb_master_req_gen #(.SLAVE_NUM(6), .ADDR_WIDTH(32), .SEL_BIT(3)) dut6 (
    .hclk(hclk), .hreset(hreset), .htrans(htrans6), .haddr(haddr),
    .hburst(hburst), .hgrant(hgrant[5:0]), .hreq(hreq6), .hburst_out(hburst_out6),
    .slave_idx(slave_idx6), .hready_out(hready6), .hresp_err(herr6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [7:0] oh(input int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx[2:0];
  endfunction

  function automatic logic [31:0] addr_of(input int idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {i3, 29'($urandom)};
  endfunction

  // Beats in a fixed burst; 0 marks the open-ended INCR.
  function automatic int burst_len(input int b);
    case (b)
      0:    return 1;
      1:    return 0;
      2, 3: return 4;
      4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] rand_others(input int idx);
    return 8'($urandom) & ~oh(idx);
  endfunction

  task automatic check_outs(input string tag, input logic [7:0] eq, input logic er, input logic ee);
    check({tag, "_hreq"}, 32'(hreq_o), 32'(eq));
    check({tag, "_hready"}, 32'(hready_o), 32'(er));
    check({tag, "_herr"}, 32'(herr_o), 32'(ee));
  endtask

  task automatic idle_cycle();
    htrans = HTRANS_IDLE;
    hgrant = 8'($urandom);
    #2;
    check_outs("idle", 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  // One master transaction. addr_done: its NONSEQ was already presented on
  // the previous transfer's last beat. b2b: end this one with NONSEQ to nidx.
  task automatic transfer(input int idx, input int burst, input int gdelay, input int incr_len,
                          input bit addr_done, input bit b2b, input int nidx, input int nburst);
    int snum, limit, cnt, stalled;
    bit g, b, last;
    snum = sel6 ? 6 : 8;
    if (!addr_done) begin
      htrans = HTRANS_NONSEQ;
      haddr  = addr_of(idx);
      hburst = hburst_type'(burst);
      hgrant = 8'($urandom);
      #2;
      check_outs("addr", 8'h00, 1'b1, 1'b0);
      tick();
    end
    if (idx >= snum) begin
      htrans = HTRANS_IDLE;
      hgrant = 8'($urandom);
      #2;
      check_outs("err1", 8'h00, 1'b0, 1'b1);
      check("err_idx", 32'(slave_idx_o), 32'(idx));
      tick();
      #2;
      check_outs("err2", 8'h00, 1'b1, 1'b1);
      tick();
      return;
    end
    for (int i = 0; i <= gdelay; i++) begin
      htrans = HTRANS_NONSEQ;
      hgrant = rand_others(idx) | ((i == gdelay) ? oh(idx) : 8'h00);
      #2;
      check_outs("req", oh(idx), 1'b0, 1'b0);
      check("req_idx", 32'(slave_idx_o), 32'(idx));
      check("req_burst", 32'(hburst_o), 32'(burst));
      tick();
    end
    limit = burst_len(burst);
    cnt = 0;
    stalled = 0;
    if (limit > 0) begin
      while (cnt < limit) begin
        if (cnt == stall_beat && stalled < stall_len) begin
          g = 1'b0;
          stalled++;
        end else begin
          g = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
        end
        b = rnd_en && ($urandom_range(5) == 0);
        last = g && !b && (cnt == limit - 1);
        htrans = b ? HTRANS_BUSY : (last && b2b) ? HTRANS_NONSEQ : HTRANS_SEQ;
        if (last && b2b) begin
          haddr  = addr_of(nidx);
          hburst = hburst_type'(nburst);
        end
        hgrant = rand_others(idx) | (g ? oh(idx) : 8'h00);
        #2;
        check_outs("beat", oh(idx), g, 1'b0);
        tick();
        if (g && !b) cnt++;
      end
    end else begin
      while (cnt < incr_len) begin
        g = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
        b = rnd_en && ($urandom_range(5) == 0);
        htrans = b ? HTRANS_BUSY : HTRANS_SEQ;
        hgrant = rand_others(idx) | (g ? oh(idx) : 8'h00);
        #2;
        check_outs("ibeat", oh(idx), g, 1'b0);
        tick();
        if (g && !b) cnt++;
      end
      do begin
        g = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
        htrans = b2b ? HTRANS_NONSEQ : HTRANS_IDLE;
        if (b2b) begin
          haddr  = addr_of(nidx);
          hburst = hburst_type'(nburst);
        end
        hgrant = rand_others(idx) | (g ? oh(idx) : 8'h00);
        #2;
        check_outs("iend", oh(idx), g, 1'b0);
        tick();
      end while (!g);
    end
  endtask

  task automatic random_run(input int n);
    int idx, burst, ni, nb, snum;
    bit pend, b2b;
    pend = 1'b0;
    ni = 0;
    nb = 0;
    snum = sel6 ? 6 : 8;
    for (int t = 0; t < n; t++) begin
      idx   = pend ? ni : int'($urandom_range(7));
      burst = pend ? nb : int'($urandom_range(7));
      b2b   = (t < n - 1) && ($urandom_range(2) == 0);
      ni    = int'($urandom_range(7));
      nb    = int'($urandom_range(7));
      transfer(idx, burst, int'($urandom_range(3)), 1 + int'($urandom_range(4)), pend, b2b, ni, nb);
      pend = b2b && (idx < snum);
      if (!pend && $urandom_range(1) == 1) idle_cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel6   = 1'b0;
    hreset = 1'b1;
    htrans = HTRANS_IDLE;
    haddr  = 32'h0;
    hburst = INCR8;
    hgrant = 8'h00;
    tick();
    tick();
    #2;
    check_outs("rst", 8'h00, 1'b1, 1'b0);
    check("rst_idx", 32'(slave_idx_o), 32'd0);
    check("rst_burst", 32'(hburst_o), 32'(SINGLE));
    hreset = 1'b0;
    tick();

    // SINGLE to 0x4000_0000 granted on the second REQ cycle
    transfer(2, 0, 1, 1, 1'b0, 1'b0, 0, 0);
    idle_cycle();

    // INCR4 to slave 7, grant held
    transfer(7, 3, 0, 1, 1'b0, 1'b0, 0, 0);
    idle_cycle();

    // INCR8 with grant dropped for 3 cycles mid-burst
    stall_beat = 3;
    stall_len  = 3;
    transfer(4, 5, 0, 1, 1'b0, 1'b0, 0, 0);
    stall_beat = -1;
    idle_cycle();

    // INCR4 to slave 1 chained straight into a SINGLE to slave 3
    transfer(1, 3, 0, 1, 1'b0, 1'b1, 3, 0);
    transfer(3, 0, 1, 1, 1'b1, 1'b0, 0, 0);
    idle_cycle();

    // Reset mid-INCR16 after 5 accepted beats
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h4000_0000;
    hburst = INCR16;
    hgrant = 8'h00;
    #2;
    tick();
    hgrant = oh(2);
    #2;
    check_outs("r16_req", 8'h04, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      htrans = HTRANS_SEQ;
      #2;
      check_outs("r16_beat", 8'h04, 1'b1, 1'b0);
      tick();
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    htrans = HTRANS_IDLE;
    hgrant = 8'h00;
    #2;
    check_outs("r16_rst", 8'h00, 1'b1, 1'b0);
    check("r16_idx", 32'(slave_idx_o), 32'd0);
    check("r16_burst", 32'(hburst_o), 32'(SINGLE));
    tick();
    transfer(5, 0, 0, 1, 1'b0, 1'b0, 0, 0);
    idle_cycle();

    // Randomized traffic on the 8-slave instance
    rnd_en = 1'b1;
    random_run(40);
    idle_cycle();

    // 6-slave instance: unmapped index 7 then random traffic
    sel6 = 1'b1;
    rnd_en = 1'b0;
    #2;
    transfer(7, 0, 0, 1, 1'b0, 1'b0, 0, 0);
    idle_cycle();
    rnd_en = 1'b1;
    random_run(30);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
